// File: rtl/work_dispatcher.sv
// work_dispatcher: central GPU work queue. Cores push queue numbers that are
// mapped through a 16-entry entry-point table into per-core staging slots,
// slots (or a host launch) feed a PC FIFO, and the FIFO head is granted
// round-robin to requesting cores. Tracks global completion.

// One staging slot per core: holds a mapped PC until it drains into the FIFO.
module work_dispatcher_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        drain,
  input  logic [15:0] push_pc,
  output logic        vld,
  output logic [15:0] pc,
  output logic        drop
);
  // Refill when empty or when the current PC leaves for the FIFO this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      pc  <= '0;
    end else if (push && (!vld || drain)) begin
      vld <= 1'b1;
      pc  <= push_pc;
    end else if (drain) begin
      vld <= 1'b0;
    end
  end

  assign drop = push && vld && !drain;
endmodule

module work_dispatcher #(
  parameter int NCORES = 4,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCORES-1:0]        queue_wen,
  input  logic [4*NCORES-1:0]      queue_number,
  input  logic [NCORES-1:0]        request_new_pc,
  output logic [16*NCORES-1:0]     new_pc,
  output logic [NCORES-1:0]        pc_grant,
  output logic [2*NCORES-1:0]      idle,
  input  logic                     ep_wen,
  input  logic [3:0]               ep_waddr,
  input  logic [15:0]              ep_wdata,
  input  logic                     launch_valid,
  input  logic [15:0]              launch_pc,
  output logic                     launch_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     all_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (NCORES > 1) ? $clog2(NCORES) : 1;

  logic [15:0]              ep_table [16];
  logic [15:0]              fifo_mem [DEPTH];
  logic [AW-1:0]            wptr, rptr;
  logic [AW:0]              cnt, cnt_nxt;
  logic                     active;
  logic [NCORES-1:0]        stg_vld, stg_drop, drain, eff_req, waiting;
  logic [NCORES-1:0][15:0]  stg_pc, pc_q;
  logic [CW-1:0]            enq_last, deq_last, enq_idx, deq_idx;
  logic                     full, empty, stg_any, enq_stage, push_fifo, pop, done_q;
  logic [15:0]              push_data;

  // First valid index after 'last', wrapping; smallest distance wins
  function automatic logic [CW-1:0] rr_pick(input logic [NCORES-1:0] v,
                                            input logic [CW-1:0] last);
    logic [CW-1:0] r;
    int idx;
    r = last;
    for (int k = NCORES; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NCORES) idx -= NCORES;
      if (v[CW'(idx)]) r = CW'(idx);
    end
    return r;
  endfunction

  for (genvar i = 0; i < NCORES; i++) begin : g_core
    work_dispatcher_slot u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (queue_wen[i]),
      .drain   (drain[i]),
      .push_pc (ep_table[queue_number[4*i +: 4]]),
      .vld     (stg_vld[i]),
      .pc      (stg_pc[i]),
      .drop    (stg_drop[i])
    );
    assign idle[2*i +: 2] = all_done ? 2'd2 : {1'b0, waiting[i]};
  end

  assign full         = (cnt == (AW+1)'(DEPTH));
  assign empty        = (cnt == '0);
  assign stg_any      = |stg_vld;
  // Host seeding only once cores' own pushes are flushed
  assign launch_ready = active && !full && !stg_any;
  // A core granted last cycle may still show its stale request
  assign eff_req      = request_new_pc & ~pc_grant;
  assign enq_idx      = rr_pick(stg_vld, enq_last);
  assign deq_idx      = rr_pick(eff_req, deq_last);
  assign enq_stage    = !full && stg_any;
  assign push_fifo    = enq_stage || (launch_valid && launch_ready);
  assign push_data    = enq_stage ? stg_pc[enq_idx] : launch_pc;
  assign pop          = !empty && (|eff_req);
  assign cnt_nxt      = cnt + (AW+1)'(push_fifo) - (AW+1)'(pop);
  assign fifo_count   = cnt;
  assign new_pc       = pc_q;
  // A rising launch cancels completion in the same cycle
  assign all_done     = done_q && !launch_valid;

  // One-hot drain of the staging slot chosen for this cycle's enqueue
  always_comb begin
    drain = '0;
    if (enq_stage) drain[enq_idx] = 1'b1;
  end

  // Entry-point table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) ep_table[i] <= '0;
    end else if (ep_wen) begin
      ep_table[ep_waddr] <= ep_wdata;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    if (push_fifo) fifo_mem[wptr] <= push_data;
  end

  // FIFO pointers, occupancy and round-robin history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      active   <= 1'b0;
      enq_last <= '0;
      deq_last <= '0;
    end else begin
      active <= 1'b1;
      cnt    <= cnt_nxt;
      if (push_fifo) wptr     <= wptr + 1'b1;
      if (pop)       rptr     <= rptr + 1'b1;
      if (enq_stage) enq_last <= enq_idx;
      if (pop)       deq_last <= deq_idx;
    end
  end

  // Registered per-core grant/idle status plus overflow and completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_grant <= '0;
      pc_q     <= '0;
      waiting  <= '0;
      overflow <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      pc_grant <= '0;
      if (pop) begin
        pc_grant[deq_idx] <= 1'b1;
        pc_q[deq_idx]     <= fifo_mem[rptr];
      end
      waiting  <= eff_req & {NCORES{empty}};
      overflow <= overflow || (|stg_drop);
      done_q   <= (cnt_nxt == '0) && !(|((stg_vld & ~drain) | queue_wen)) &&
                  (&eff_req) && !launch_valid && !pop;
    end
  end
endmodule

// File: tb/tb_work_dispatcher.sv
// Randomized + directed bench for work_dispatcher against a queue-based model.
module tb_work_dispatcher;
  localparam int N = 4;
  localparam int D = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      queue_wen = '0, request_new_pc = '0;
  logic [4*N-1:0]    queue_number = '0;
  logic [16*N-1:0]   new_pc;
  logic [N-1:0]      pc_grant;
  logic [2*N-1:0]    idle;
  logic              ep_wen = 1'b0;
  logic [3:0]        ep_waddr = '0;
  logic [15:0]       ep_wdata = '0;
  logic              launch_valid = 1'b0;
  logic [15:0]       launch_pc = '0;
  logic              launch_ready;
  logic [$clog2(D):0] fifo_count;
  logic              overflow, all_done;

  // next-cycle stimulus
  logic              d_rst = 1'b0, d_ep_wen = 1'b0, d_lv = 1'b0;
  logic [N-1:0]      d_wen = '0, d_req = '0;
  logic [4*N-1:0]    d_qn = '0;
  logic [3:0]        d_ep_waddr = '0;
  logic [15:0]       d_ep_wdata = '0, d_lpc = '0;

  int n_checks = 0, n_fail = 0;

  // reference model state
  logic [15:0] m_ep [16];
  logic [15:0] m_q [$];
  logic        m_sv [N];
  logic [15:0] m_sp [N];
  logic [15:0] m_pc [N];
  logic [N-1:0] m_grant, m_wait;
  int          m_enq_last, m_deq_last;
  logic        m_ovf, m_done, m_active;

  work_dispatcher #(.NCORES(N), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .queue_wen(queue_wen), .queue_number(queue_number),
    .request_new_pc(request_new_pc), .new_pc(new_pc), .pc_grant(pc_grant), .idle(idle),
    .ep_wen(ep_wen), .ep_waddr(ep_waddr), .ep_wdata(ep_wdata),
    .launch_valid(launch_valid), .launch_pc(launch_pc), .launch_ready(launch_ready),
    .fifo_count(fifo_count), .overflow(overflow), .all_done(all_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic m_any_stage();
    logic a = 1'b0;
    for (int i = 0; i < N; i++) a |= m_sv[i];
    return a;
  endfunction

  function automatic logic m_lready();
    return m_active && (m_q.size() < D) && !m_any_stage();
  endfunction

  function automatic logic [63:0] m_newpc();
    logic [63:0] r = '0;
    for (int i = 0; i < N; i++) r[16*i +: 16] = m_pc[i];
    return r;
  endfunction

  function automatic logic [7:0] m_idle(input logic done);
    logic [7:0] r = '0;
    for (int i = 0; i < N; i++) r[2*i +: 2] = done ? 2'd2 : {1'b0, m_wait[i]};
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ep[i] = '0;
    m_q.delete();
    for (int i = 0; i < N; i++) begin m_sv[i] = 1'b0; m_sp[i] = '0; m_pc[i] = '0; end
    m_grant = '0; m_wait = '0; m_enq_last = 0; m_deq_last = 0;
    m_ovf = 1'b0; m_done = 1'b0; m_active = 1'b0;
  endtask

  // One rising edge of the spec's behaviour, from the inputs now applied
  task automatic model_step();
    int sz, drained, winner, idx;
    logic lr;
    logic [N-1:0] eff;
    sz = m_q.size();
    lr = m_lready();
    for (int i = 0; i < N; i++) eff[i] = request_new_pc[i] && !m_grant[i];
    drained = -1;
    if (sz < D)
      for (int k = 1; k <= N; k++) begin
        idx = (m_enq_last + k) % N;
        if (drained < 0 && m_sv[idx]) drained = idx;
      end
    winner = -1;
    if (sz > 0)
      for (int k = 1; k <= N; k++) begin
        idx = (m_deq_last + k) % N;
        if (winner < 0 && eff[idx]) winner = idx;
      end
    m_wait = eff & {N{sz == 0}};
    m_grant = '0;
    if (winner >= 0) begin
      m_pc[winner] = m_q.pop_front();
      m_grant[winner] = 1'b1;
      m_deq_last = winner;
    end
    if (drained >= 0) begin
      m_q.push_back(m_sp[drained]);
      m_enq_last = drained;
    end else if (launch_valid && lr) begin
      m_q.push_back(launch_pc);
    end
    for (int i = 0; i < N; i++) begin
      if (queue_wen[i]) begin
        if (!m_sv[i] || drained == i) begin
          m_sv[i] = 1'b1;
          m_sp[i] = m_ep[queue_number[4*i +: 4]];
        end else m_ovf = 1'b1;
      end else if (drained == i) m_sv[i] = 1'b0;
    end
    if (ep_wen) m_ep[ep_waddr] = ep_wdata;
    m_done = (m_q.size() == 0) && !m_any_stage() && (&eff) && !launch_valid && (winner < 0);
    m_active = 1'b1;
  endtask

  // Check registered outputs, apply stimulus, check combinational ones, step model
  task automatic tick();
    @(negedge clk);
    chk("pc_grant", 64'(pc_grant), 64'(m_grant));
    chk("new_pc", new_pc, m_newpc());
    chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("launch_ready", 64'(launch_ready), 64'(m_lready()));
    rst_n = d_rst; queue_wen = d_wen; queue_number = d_qn; request_new_pc = d_req;
    ep_wen = d_ep_wen; ep_waddr = d_ep_waddr; ep_wdata = d_ep_wdata;
    launch_valid = d_lv; launch_pc = d_lpc;
    if (!d_rst) model_reset();
    #1;
    chk("all_done", 64'(all_done), 64'(m_done && !launch_valid));
    chk("idle", 64'(idle), 64'(m_idle(m_done && !launch_valid)));
    if (d_rst) model_step();
  endtask

  initial begin
    model_reset();
    // reset state
    tick(); tick();
    chk("rst_grant", 64'(pc_grant), 64'd0);
    chk("rst_newpc", new_pc, 64'd0);
    chk("rst_idle", 64'(idle), 64'd0);
    chk("rst_ready", 64'(launch_ready), 64'd0);
    chk("rst_done", 64'(all_done), 64'd0);
    d_rst = 1'b1; tick();

    // table write and launch, core 0 fetches
    d_ep_wen = 1'b1; d_ep_waddr = 4'd3; d_ep_wdata = 16'h0040; tick();
    d_ep_wen = 1'b0; d_lv = 1'b1; d_lpc = 16'h0010; tick();
    d_lv = 1'b0; d_req = 4'b0001; tick();
    chk("a_count1", 64'(fifo_count), 64'd1);
    d_req = 4'b0000; tick();
    chk("a_grant", 64'(pc_grant), 64'h1);
    chk("a_newpc", 64'(new_pc[15:0]), 64'h0010);
    chk("a_count0", 64'(fifo_count), 64'd0);
    chk("a_idle0", 64'(idle[1:0]), 64'd0);

    // push mapping: core 1 pushes queue 3, core 2 waits for it
    d_wen = 4'b0010; d_qn = 16'h0030; d_req = 4'b0100; tick();
    d_wen = 4'b0000; tick();
    chk("b_idle_wait", 64'(idle[5:4]), 64'd1);
    tick();
    d_req = 4'b0000; tick();
    chk("b_grant", 64'(pc_grant), 64'h4);
    chk("b_newpc", 64'(new_pc[47:32]), 64'h0040);

    // fairness: 8 PCs, all cores request; last grant went to core 2
    for (int k = 0; k < 8; k++) begin d_lv = 1'b1; d_lpc = 16'(16'h0100 + k); tick(); end
    d_lv = 1'b0; d_req = 4'hF;
    for (int j = 0; j < 14; j++) begin
      tick();
      if (j >= 1 && j <= 8) chk("c_rr", 64'(pc_grant), 64'(4'b0001 << ((2 + j) % 4)));
    end

    // completion, then a launch cancels it in the same cycle
    chk("d_done", 64'(all_done), 64'd1);
    chk("d_idle2", 64'(idle), 64'hAA);
    d_lv = 1'b1; d_lpc = 16'h0ABC; tick();
    chk("d_done_drop", 64'(all_done), 64'd0);
    d_lv = 1'b0; d_req = 4'h0; tick(); tick(); tick();

    // fill FIFO, then two pushes per core with no requests
    for (int t = 0; t < 40 && m_q.size() < D; t++) begin
      d_lv = 1'b1; d_lpc = 16'($urandom); tick();
    end
    d_lv = 1'b0; tick();
    chk("e_full", 64'(fifo_count), 64'd16);
    chk("e_ready0", 64'(launch_ready), 64'd0);
    for (int i = 0; i < N; i++) begin d_wen = 4'(1 << i); d_qn = 16'($urandom); tick(); end
    d_wen = '0; tick();
    chk("e_ovf0", 64'(overflow), 64'd0);
    for (int i = 0; i < N; i++) begin d_wen = 4'(1 << i); d_qn = 16'($urandom); tick(); end
    d_wen = '0; tick();
    chk("e_ovf1", 64'(overflow), 64'd1);
    chk("e_hold", 64'(fifo_count), 64'd16);
    chk("e_ready_hold", 64'(launch_ready), 64'd0);

    // reset mid-operation with 5 entries queued and core 0 requesting
    d_req = 4'b0001;
    for (int t = 0; t < 80 && m_q.size() != 5; t++) tick();
    @(posedge clk); #2;
    chk("f_cnt5", 64'(fifo_count), 64'd5);
    rst_n = 1'b0; #1;
    model_reset();
    chk("f_newpc", new_pc, 64'd0);
    chk("f_grant", 64'(pc_grant), 64'd0);
    chk("f_idle", 64'(idle), 64'd0);
    chk("f_count", 64'(fifo_count), 64'd0);
    chk("f_ovf", 64'(overflow), 64'd0);
    chk("f_done", 64'(all_done), 64'd0);
    chk("f_ready", 64'(launch_ready), 64'd0);
    d_rst = 1'b0; tick();
    d_rst = 1'b1; d_req = 4'hF; tick(); tick(); tick();
    chk("f_post_count", 64'(fifo_count), 64'd0);
    chk("f_post_grant", 64'(pc_grant), 64'd0);

    // randomized traffic
    d_req = '0;
    for (int c = 0; c < 1500; c++) begin
      d_ep_wen = ($urandom_range(3) == 0);
      d_ep_waddr = 4'($urandom);
      d_ep_wdata = 16'($urandom);
      for (int i = 0; i < N; i++) d_wen[i] = ($urandom_range(5) == 0);
      d_qn = 16'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!d_req[i]) d_req[i] = ($urandom_range(3) == 0);
        else if (m_grant[i]) d_req[i] = 1'($urandom_range(1));
      end
      d_lv = ($urandom_range(2) == 0);
      d_lpc = 16'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
